// File: rtl/memory_arbiter_pkg.sv
// Shared types and address-map helpers for the two-requester memory arbiter.
package memory_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        ACK     = 2'd3
    } state_t;

    localparam logic [7:0] ROM_LAST = 8'h7F;
    localparam logic [7:0] RW_FIRST = 8'h80;
    localparam logic [7:0] RW_LAST  = 8'hDF;
    localparam logic [7:0] IO_FIRST = 8'hF0;

    // RW RAM and the I/O ports accept writes; ROM and the hole never do.
    function automatic logic is_writable(input logic [7:0] addr);
        return ((addr >= RW_FIRST) && (addr <= RW_LAST)) || (addr >= IO_FIRST);
    endfunction

    function automatic logic is_unmapped(input logic [7:0] addr);
        return (addr > RW_LAST) && (addr < IO_FIRST);
    endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// Requester-side handshake buses plus the single-port memory bus.
interface memory_arbiter_if;

    logic       req_0, req_1;
    logic       write_0, write_1;
    logic [7:0] addr_0, addr_1;
    logic [7:0] wdata_0, wdata_1;
    logic       gnt_0, gnt_1;
    logic       ack_0, ack_1;
    logic       err_0, err_1;
    logic [7:0] rdata_0, rdata_1;

    logic [7:0] mem_address;
    logic [7:0] mem_data_in;
    logic       mem_write;
    logic [7:0] mem_data_out;

    modport master (
        output req_0, req_1, write_0, write_1, addr_0, addr_1, wdata_0, wdata_1,
        input  gnt_0, gnt_1, ack_0, ack_1, err_0, err_1, rdata_0, rdata_1
    );

    modport slave (
        input  req_0, req_1, write_0, write_1, addr_0, addr_1, wdata_0, wdata_1,
        output gnt_0, gnt_1, ack_0, ack_1, err_0, err_1, rdata_0, rdata_1,
        output mem_address, mem_data_in, mem_write,
        input  mem_data_out
    );

    modport mem (
        input  mem_address, mem_data_in, mem_write,
        output mem_data_out
    );

endinterface

// File: rtl/memory_arbiter_rr_arbiter_2.sv
// Combinational two-way winner select; the parent owns the last-served flop.
module rr_arbiter_2 #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic req_0,
    input  logic req_1,
    input  logic last_served,
    output logic winner
);

    // On a tie, round-robin hands the slot to whoever was not served last.
    always_comb begin
        winner = 1'b0;
        if (req_0 && req_1) begin
            winner = FIXED_PRIO ? 1'b0 : ~last_served;
        end else if (req_1) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Serialises two requesters onto the single-port ROM/RAM/I/O memory system,
// covering its one-cycle read latency and enforcing the address map.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    memory_arbiter_if.slave bus
);

    state_t     state, state_next;
    logic       owner;
    logic       last_served;
    logic       winner;
    logic       any_req;
    logic       owner_write;
    logic [7:0] owner_addr;
    logic [7:0] owner_wdata;
    logic       txn_err;
    logic [7:0] capture_data;
    logic [7:0] rdata_0_q, rdata_1_q;

    assign any_req     = bus.req_0 | bus.req_1;
    assign owner_write = owner ? bus.write_1 : bus.write_0;
    assign owner_addr  = owner ? bus.addr_1  : bus.addr_0;
    assign owner_wdata = owner ? bus.wdata_1 : bus.wdata_0;
    assign txn_err     = (owner_write && (owner_addr <= ROM_LAST)) || is_unmapped(owner_addr);
    assign capture_data = is_unmapped(owner_addr) ? 8'h00 : bus.mem_data_out;

    rr_arbiter_2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_rr (
        .req_0       (bus.req_0),
        .req_1       (bus.req_1),
        .last_served (last_served),
        .winner      (winner)
    );

    // NOTE: reset is synchronous here, and all flops use <= so every one samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= 1'b0;
            last_served <= 1'b1;
        end else begin
            state <= state_next;
            if (state == IDLE && any_req) begin
                owner       <= winner;
                last_served <= winner;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = ACCESS;
            ACCESS:  state_next = owner_write ? ACK : CAPTURE;
            CAPTURE: state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Memory data is valid in CAPTURE, one cycle after the address went out.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_0_q <= 8'h00;
            rdata_1_q <= 8'h00;
        end else if (state == CAPTURE) begin
            if (owner) rdata_1_q <= capture_data;
            else       rdata_0_q <= capture_data;
        end
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        bus.gnt_0       = 1'b0;
        bus.gnt_1       = 1'b0;
        bus.ack_0       = 1'b0;
        bus.ack_1       = 1'b0;
        bus.err_0       = 1'b0;
        bus.err_1       = 1'b0;
        bus.mem_address = 8'h00;
        bus.mem_data_in = 8'h00;
        bus.mem_write   = 1'b0;

        if (state != IDLE) begin
            bus.gnt_0 = ~owner;
            bus.gnt_1 = owner;
        end

        case (state)
            ACCESS: begin
                bus.mem_address = owner_addr;
                bus.mem_data_in = owner_wdata;
                bus.mem_write   = owner_write && is_writable(owner_addr);
            end
            CAPTURE: bus.mem_address = owner_addr;
            ACK: begin
                bus.ack_0 = ~owner;
                bus.ack_1 = owner;
                bus.err_0 = ~owner && txn_err;
                bus.err_1 = owner && txn_err;
            end
            default: ;
        endcase
    end

    assign bus.rdata_0 = rdata_0_q;
    assign bus.rdata_1 = rdata_1_q;

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Two-port arbiter that shares the single-port memory system (128×8 ROM, 96×8 RW RAM, 16 I/O ports) between two bus masters: requester 0 (CPU) and requester 1 (DMA/loader). It serialises transactions and drives the memory address, data and write lines. It accounts for the one-cycle synchronous read latency of ROM and RAM, and returns registered read data with a one-cycle acknowledge. It also enforces the address map by suppressing writes to ROM and flagging accesses to the unmapped hole.

## Interface
Parameters:
- FIXED_PRIO, 0, 0: round-robin between requesters; 1: requester 0 always wins ties.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_0 / req_1  in  1  transaction request; address, write and write data held stable until the matching ack.
- write_0 / write_1  in  1  1 = write, 0 = read.
- addr_0 / addr_1  in  8  byte address.
- wdata_0 / wdata_1  in  8  write data.
- gnt_0 / gnt_1  out  1  requester owns the memory; high from ACCESS through ACK.
- ack_0 / ack_1  out  1  one-cycle completion pulse.
- err_0 / err_1  out  1  valid with ack: ROM write or unmapped access.
- rdata_0 / rdata_1  out  8  registered read data; held until that requester's next read completes.
- mem_address  out  8  to memory `address`.
- mem_data_in  out  8  to memory `data_in`.
- mem_write  out  1  to memory `write`.
- mem_data_out  in  8  from memory `data_out`.

## Operation
- States: IDLE, ACCESS, CAPTURE, ACK.
- IDLE
  - If no req is high, stay in IDLE.
  - Otherwise pick a winner into the owner register and go to ACCESS.
  - FIXED_PRIO=0: on a tie, grant the requester not served last. The last-served register resets to 1, so requester 0 wins the first tie.
- ACCESS
  - mem_address = owner addr; mem_data_in = owner wdata.
  - mem_write = owner write AND the address is in RW RAM (0x80–0xDF) or the I/O ports (0xF0–0xFF).
  - Next state: ACK on a write, CAPTURE on a read.
- CAPTURE
  - mem_address is held and mem_write = 0.
  - The owner's rdata is loaded from mem_data_out, or 0x00 if the address is unmapped (0xE0–0xEF).
  - Next state: ACK.
- ACK
  - ack_owner = 1; err_owner = 1 if the transaction was a write to 0x00–0x7F, or any access to 0xE0–0xEF.
  - mem_write = 0; next state: IDLE.
- A write to ROM or the hole performs no memory write but still completes, with err set.
- Outside ACCESS and CAPTURE: mem_address = 0x00, mem_data_in = 0x00, mem_write = 0.
- gnt, ack, err and mem_* are decoded from registered state and owner only (no req→gnt combinational path).

## Timing
- Reset values: state IDLE, all gnt/ack/err 0, rdata_0 = rdata_1 = 0x00, mem_write 0, mem_address 0x00, mem_data_in 0x00, last-served 1.
- Read latency: req seen in IDLE at cycle T, then ACCESS at T+1, CAPTURE at T+2, ack at T+3.
- Write latency: the memory write occurs on the edge ending T+1; ack at T+2.
- rdata is valid in the ack cycle and remains stable afterwards.
- A req still high in the IDLE cycle after ACK is treated as a new transaction. Requesters drop req on the edge after ack to avoid a repeat.
- Peak throughput: one read per 4 cycles or one write per 3 cycles. Alternating service is guaranteed under continuous contention when FIXED_PRIO=0.
- The losing requester keeps req high and is served next. Its inputs are not sampled until its own ACCESS.
- Reset mid-transaction:
  - Return to IDLE on the next edge with no ack.
  - A write in progress at that edge is not guaranteed to be suppressed (the memory samples the same edge).
  - rdata is cleared to 0x00.

## Structure
- Package `memory_arbiter_pkg` holds:
  - the state enum (IDLE, ACCESS, CAPTURE, ACK);
  - address-map constants ROM_LAST = 8'h7F, RW_FIRST = 8'h80, RW_LAST = 8'hDF, IO_FIRST = 8'hF0;
  - functions `is_writable(addr)` and `is_unmapped(addr)`.
- Sub-module `rr_arbiter_2`: combinational winner select from req_0/req_1, last-served and FIXED_PRIO. Last-served is updated in the parent on IDLE→ACCESS.

## Test plan
- **Single read:** req_0 read of 0x05 (ROM holds 0xA7) → gnt_0 from T+1 to T+3, ack_0 at T+3, rdata_0 = 0xA7, err_0 = 0, mem_write never high.
- **Write then read back:** req_1 writes 0x3C to 0x90, then reads 0x90 → ack_1 at T+2 with mem_write high only in T+1; the read returns rdata_1 = 0x3C.
- **Contention, FIXED_PRIO=0:** both reqs held high for 4 transactions → grants go 0,1,0,1 with no overlapping gnt; with FIXED_PRIO=1 all 4 go to requester 0 while it keeps requesting.
- **Protection:** req_0 writes 0xFF to 0x10 → mem_write stays 0 and ack_0 comes with err_0 = 1. A read of 0xE4 returns rdata 0x00 with err = 1.
- **I/O path:** requester 1 writes 0x55 to 0xF3 → port_out_03 = 0x55. With port_in_07 = 0x81, requester 0 reads 0xF7 → rdata_0 = 0x81.
- **Reset mid-read:** assert reset during CAPTURE → no ack, state IDLE next cycle, rdata cleared to 0x00, and a subsequent read completes normally.
